// File: rtl/shared_mem_arbiter.sv
// Single-port word memory shared by the CPU and a host/debug port.
// Host-priority arbitration with bounded CPU starvation; auto-clears after reset.
module shared_mem_arbiter #(
   parameter int unsigned BIT_WIDTH    = 32,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned HOST_MAX_RUN = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [BIT_WIDTH-1:0] cpu_addr,
   input  logic [BIT_WIDTH-1:0] cpu_wdata,
   output logic                 cpu_ready,
   output logic                 cpu_rvalid,
   output logic [BIT_WIDTH-1:0] cpu_rdata,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [BIT_WIDTH-1:0] host_addr,
   input  logic [BIT_WIDTH-1:0] host_wdata,
   output logic                 host_ready,
   output logic                 host_rvalid,
   output logic [BIT_WIDTH-1:0] host_rdata,
   output logic                 addr_err,
   output logic                 init_busy
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned RUN_W = $clog2(HOST_MAX_RUN + 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     clr_idx;
   logic [RUN_W-1:0]     host_run;
   logic [BIT_WIDTH-1:0] mem [DEPTH];

   logic                 host_grant;
   logic                 cpu_grant;
   logic                 any_grant;
   logic                 sel_we;
   logic                 sel_in_range;
   logic [BIT_WIDTH-1:0] sel_addr;
   logic [BIT_WIDTH-1:0] sel_wdata;
   logic [IDX_W-1:0]     sel_idx;
   logic                 host_run_full;

   assign host_run_full = (host_run >= RUN_W'(HOST_MAX_RUN));

   // Host wins unless it has used up its run while the CPU is waiting.
   always_comb begin
      host_grant = 1'b0;
      cpu_grant  = 1'b0;
      if (state == ST_RUN) begin
         if (host_req && (!cpu_req || !host_run_full)) begin
            host_grant = 1'b1;
         end else if (cpu_req) begin
            cpu_grant = 1'b1;
         end
      end
   end

   assign any_grant  = host_grant | cpu_grant;
   assign host_ready = host_grant;
   assign cpu_ready  = cpu_grant;
   assign init_busy  = (state == ST_CLEAR);

   // The granted master owns the single memory port this cycle.
   assign sel_we       = host_grant ? host_we    : cpu_we;
   assign sel_addr     = host_grant ? host_addr  : cpu_addr;
   assign sel_wdata    = host_grant ? host_wdata : cpu_wdata;
   assign sel_idx      = sel_addr[IDX_W+1:2];
   assign sel_in_range = ((sel_addr >> (IDX_W + 2)) == '0);

   // Storage: zero-fill during CLEAR, otherwise in-range granted writes.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_idx] <= '0;
      end else if (!reset && any_grant && sel_we && sel_in_range) begin
         mem[sel_idx] <= sel_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_CLEAR;
         clr_idx     <= '0;
         host_run    <= '0;
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         cpu_rdata   <= '0;
         host_rdata  <= '0;
         addr_err    <= 1'b0;
      end else begin
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         addr_err    <= 1'b0;
         case (state)
            ST_CLEAR: begin
               clr_idx <= clr_idx + IDX_W'(1);
               if (clr_idx == IDX_W'(DEPTH - 1)) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Starvation counter only runs while the CPU is actually waiting.
               if (cpu_grant || !cpu_req) begin
                  host_run <= '0;
               end else if (host_grant && !host_run_full) begin
                  host_run <= host_run + RUN_W'(1);
               end
               if (any_grant) begin
                  addr_err <= !sel_in_range;
               end
               if (host_grant && !host_we) begin
                  host_rvalid <= 1'b1;
                  host_rdata  <= sel_in_range ? mem[sel_idx] : '0;
               end
               if (cpu_grant && !cpu_we) begin
                  cpu_rvalid <= 1'b1;
                  cpu_rdata  <= sel_in_range ? mem[sel_idx] : '0;
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

endmodule
